fifo_downsizer: RTL and testbench



---
 rtl/fifo_downsizer_pkg.sv | 14 +
 rtl/fifo_downsizer.sv | 96 +++++++++
 tb/tb_fifo_downsizer.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/fifo_downsizer_pkg.sv
// Shared types and helpers for the FIFO-to-narrow-stream downsizer.
package fifo_downsizer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Chunk index width; a single-chunk word still needs a 1-bit index.
  function automatic int idx_width(input int ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

endpackage

// File: rtl/fifo_downsizer.sv
// Pops wide FIFO words and replays them as RATIO narrow chunks on a valid/ready stream.
// Define FIFO_DOWNSIZER_MSB_FIRST_EN to emit the most-significant chunk first.
module fifo_downsizer
  import fifo_downsizer_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int OUT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_drop,
  output logic [OUT_WIDTH-1:0]  chunk_o,
  output logic                  chunk_valid,
  input  logic                  chunk_ready,
  output logic                  chunk_last,
  output logic                  busy
);

  localparam int RATIO = DATA_WIDTH / OUT_WIDTH;
  localparam int IW    = idx_width(RATIO);
  localparam logic [IW-1:0] IDX_LAST = IW'(RATIO - 1);

  if ((DATA_WIDTH % OUT_WIDTH) != 0 || OUT_WIDTH > DATA_WIDTH) begin : g_bad_ratio
    $fatal(1, "fifo_downsizer: DATA_WIDTH must be a positive multiple of OUT_WIDTH");
  end

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  hs, last, load;

  assign hs   = chunk_valid & chunk_ready;
  assign last = (idx_q == IDX_LAST);
  // Reload on the final handshake too, so consecutive words leave no bubble.
  assign load = ~rst & ~fifo_empty & ((state_q == IDLE) | ((state_q == SEND) & hs & last));
  assign fifo_drop = load;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (load) begin
          shreg_d = fifo_data;
          idx_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (hs) begin
          if (!last) begin
`ifdef FIFO_DOWNSIZER_MSB_FIRST_EN
            shreg_d = shreg_q << OUT_WIDTH;
`else
            shreg_d = shreg_q >> OUT_WIDTH;
`endif
            idx_d   = idx_q + IW'(1);
          end else if (load) begin
            shreg_d = fifo_data;
            idx_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    chunk_valid = (state_q == SEND);
    busy        = (state_q == SEND);
    chunk_last  = (state_q == SEND) & last;
`ifdef FIFO_DOWNSIZER_MSB_FIRST_EN
    chunk_o     = shreg_q[DATA_WIDTH-1 -: OUT_WIDTH];
`else
    chunk_o     = shreg_q[OUT_WIDTH-1:0];
`endif
  end

endmodule

// File: tb/tb_fifo_downsizer.sv
// Randomised bench: a 32->8 and a 32->32 downsizer share stimulus, each checked against a chunk-queue model.
module tb_fifo_downsizer;

  localparam int DW = 32;
  localparam int R0 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, ready;
  logic empty0, drop0, valid0, last0, busy0;
  logic [DW-1:0] data0;
  logic [7:0]    chunk0;
  logic empty1, drop1, valid1, last1, busy1;
  logic [DW-1:0] data1, chunk1;

  int vectors = 0;
  int errors  = 0;
  int drops0  = 0;

  logic [DW-1:0] fq0[$];
  logic [DW-1:0] fq1[$];
  logic [8:0]    exp0[$];   // {last, chunk}
  logic [DW-1:0] exp1[$];   // every chunk is a whole word, always last
  logic [7:0]    log0[$];   // accepted chunks of the 32->8 instance

  fifo_downsizer #(.DATA_WIDTH(DW), .OUT_WIDTH(8)) u_dut0 (
    .clk(clk), .rst(rst), .fifo_empty(empty0), .fifo_data(data0), .fifo_drop(drop0),
    .chunk_o(chunk0), .chunk_valid(valid0), .chunk_ready(ready), .chunk_last(last0), .busy(busy0)
  );

  fifo_downsizer #(.DATA_WIDTH(DW), .OUT_WIDTH(DW)) u_dut1 (
    .clk(clk), .rst(rst), .fifo_empty(empty1), .fifo_data(data1), .fifo_drop(drop1),
    .chunk_o(chunk1), .chunk_valid(valid1), .chunk_ready(ready), .chunk_last(last1), .busy(busy1)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    vectors++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic logic [7:0] chunk_of(input logic [DW-1:0] w, input int k);
`ifdef FIFO_DOWNSIZER_MSB_FIRST_EN
    return w[DW-1-8*k -: 8];
`else
    return w[8*k +: 8];
`endif
  endfunction

  task automatic refresh();
    empty0 = (fq0.size() == 0);
    data0  = empty0 ? '0 : fq0[0];
    empty1 = (fq1.size() == 0);
    data1  = empty1 ? '0 : fq1[0];
  endtask

  task automatic push(input logic [DW-1:0] w);
    fq0.push_back(w);
    fq1.push_back(w);
    refresh();
  endtask

  // One clock: check outputs at the falling edge, then advance FIFO and model past the rising edge.
  task automatic cycle();
    logic d0, d1, h0, h1;
    logic [DW-1:0] w0, w1;
    @(negedge clk);
    chk("valid0", valid0, exp0.size() != 0);
    chk("busy0", busy0, exp0.size() != 0);
    chk("drop0", drop0, !rst && !empty0 && (exp0.size() == 0 || (exp0.size() == 1 && ready)));
    if (exp0.size() != 0) chk("chunk0", {last0, chunk0}, exp0[0]);
    chk("valid1", valid1, exp1.size() != 0);
    chk("busy1", busy1, exp1.size() != 0);
    chk("drop1", drop1, !rst && !empty1 && (exp1.size() == 0 || (exp1.size() == 1 && ready)));
    if (exp1.size() != 0) chk("chunk1", {last1, chunk1}, {1'b1, exp1[0]});
    h0 = valid0 & ready; d0 = drop0; w0 = data0;
    h1 = valid1 & ready; d1 = drop1; w1 = data1;
    if (h0) log0.push_back(chunk0);
    @(posedge clk);
    #1;
    if (h0 && exp0.size() != 0) void'(exp0.pop_front());
    if (d0 && fq0.size() != 0) begin
      drops0++;
      for (int k = 0; k < R0; k++) exp0.push_back({k == R0 - 1, chunk_of(w0, k)});
      void'(fq0.pop_front());
    end
    if (h1 && exp1.size() != 0) void'(exp1.pop_front());
    if (d1 && fq1.size() != 0) begin
      exp1.push_back(w1);
      void'(fq1.pop_front());
    end
    if (rst) begin
      exp0.delete();
      exp1.delete();
    end
    refresh();
  endtask

  initial begin
    int d;
    logic [7:0] want8;
    logic [31:0] seq;
    rst = 1'b1; ready = 1'b0;
    refresh();
    cycle();
    chk("rst_valid0", valid0, 0); chk("rst_last0", last0, 0);
    chk("rst_busy0", busy0, 0);   chk("rst_chunk0", chunk0, 0);
    chk("rst_valid1", valid1, 0); chk("rst_chunk1", chunk1, 0);
    push(32'hDEAD_BEEF);          // drop must stay low while reset is held
    cycle();
    rst = 1'b0; ready = 1'b1;
    for (int i = 0; i < 8; i++) cycle();

    // single word
    log0.delete(); d = drops0;
    push(32'hA1B2C3D4);
    for (int i = 0; i < 7; i++) cycle();
    chk("single_drops", drops0 - d, 1);
    chk("single_len", log0.size(), 4);
    if (log0.size() == 4) begin
      seq = {log0[0], log0[1], log0[2], log0[3]};
`ifdef FIFO_DOWNSIZER_MSB_FIRST_EN
      chk("single_seq", seq, 32'hA1B2C3D4);
`else
      chk("single_seq", seq, 32'hD4C3B2A1);
`endif
    end

    // back-to-back
    log0.delete(); d = drops0;
    push(32'h03020100); push(32'h07060504);
    for (int i = 0; i < 11; i++) cycle();
    chk("b2b_drops", drops0 - d, 2);
    chk("b2b_len", log0.size(), 8);
    for (int i = 0; i < 8 && i < log0.size(); i++) begin
`ifdef FIFO_DOWNSIZER_MSB_FIRST_EN
      want8 = 8'((i / 4) * 4 + 3 - (i % 4));
`else
      want8 = 8'(i);
`endif
      chk("b2b_seq", log0[i], want8);
    end

    // backpressure 1,0,0,1
    d = drops0;
    for (int i = 0; i < 3; i++) push($urandom);
    for (int i = 0; i < 60; i++) begin
      ready = (i % 4 == 0) || (i % 4 == 3);
      cycle();
    end
    chk("bp_drops", drops0 - d, 3);

    // reset mid-word
    ready = 1'b1; log0.delete();
    push(32'h11223344);
    for (int i = 0; i < 20 && log0.size() < 2; i++) cycle();
    chk("mid_two", log0.size(), 2);
    push(32'h55667788);
    rst = 1'b1; ready = 1'b0;
    cycle();
    rst = 1'b0;
    chk("mid_valid", valid0, 0);
    chk("mid_busy", busy0, 0);
    ready = 1'b1; log0.delete();
    for (int i = 0; i < 8; i++) cycle();
    chk("mid_len", log0.size(), 4);
`ifdef FIFO_DOWNSIZER_MSB_FIRST_EN
    if (log0.size() != 0) chk("mid_first", log0[0], 8'h55);
`else
    if (log0.size() != 0) chk("mid_first", log0[0], 8'h88);
`endif

    // random traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      ready = ($urandom_range(3) != 0);
      rst   = ($urandom_range(59) == 0);
      if (fq0.size() < 6 && fq1.size() < 6 && $urandom_range(2) == 0) push($urandom);
      cycle();
    end
    rst = 1'b0; ready = 1'b1;
    for (int i = 0; i < 40; i++) cycle();
    chk("drain0", exp0.size() + fq0.size(), 0);
    chk("drain1", exp1.size() + fq1.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
